// File: rtl/sif_master.sv
// sif_master
// Parametrised serial-interface master. A rising edge on the level request en
// frames one DW-bit word with sen, shifts it out on sck/sdat and captures the
// peripheral's sdi bits into rdata.
//
// Parameters:
//   DW        word width in bits (>= 2)
//   DIV       sck half-period in clk cycles (>= 1)
//   MSB_FIRST 0: bit 0 shifted first, 1: bit DW-1 shifted first
//   CPOL      sck idle level; the active edge is CPOL -> ~CPOL
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   en     in   level request, transaction starts on its synchronised rising edge
//   data   in   transmit word, captured at transaction start
//   sdi    in   serial read data from peripheral
//   sck    out  serial clock (registered)
//   sdat   out  serial write data (registered)
//   sen    out  active-high frame enable (registered)
//   busy   out  high while the FSM is not idle
//   done   out  one-cycle pulse in the cycle sen first reads low (registered)
//   rdata  out  last captured read word (registered)
module sif_master #(
    parameter int DW        = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit CPOL      = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] data,
    input  logic          sdi,
    output logic          sck,
    output logic          sdat,
    output logic          sen,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_en_d;
    logic          r_en_dd;
    logic [DW-1:0] r_shreg;
    logic [DW-1:0] r_cap;
    logic [BW-1:0] r_bit_cnt;
    logic [CW-1:0] r_div_cnt;
    logic          r_phase;     // 0: idle half of a bit, 1: active half
    logic          r_done_p;

    logic          w_en_rise;
    logic          w_half_end;
    logic          w_last_bit;
    logic [BW-1:0] w_bit_idx;
    logic          w_cur_bit;
    logic          w_sen_p;
    logic          w_sck_p;
    logic          w_sdat_p;
    logic          w_done_p;

    assign w_en_rise  = r_en_d & ~r_en_dd;
    assign w_half_end = (r_div_cnt == DIV_LAST);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    // Bit counter always counts shift order; map it to a word position.
    assign w_bit_idx  = MSB_FIRST ? (BIT_LAST - r_bit_cnt) : r_bit_cnt;
    assign w_cur_bit  = r_shreg[w_bit_idx];
    assign busy       = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_sen_p     = 1'b0;
        w_sck_p     = CPOL;
        w_sdat_p    = 1'b0;
        w_done_p    = 1'b0;
        case (r_state)
            IDLE: begin
                // First idle cycle after a frame keeps the last bit on sdat so
                // that sdat drops one cycle after sen.
                w_sdat_p = r_done_p & w_cur_bit;
                if (w_en_rise) begin
                    w_state_nxt = LEAD;
                end
            end
            LEAD: begin
                w_sen_p  = 1'b1;
                w_sdat_p = w_cur_bit;
                if (w_half_end) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_sen_p  = 1'b1;
                w_sdat_p = w_cur_bit;
                w_sck_p  = r_phase ? ~CPOL : CPOL;
                if (w_half_end && r_phase && w_last_bit) begin
                    w_state_nxt = TAIL;
                end
            end
            TAIL: begin
                w_sen_p  = 1'b1;
                w_sdat_p = w_cur_bit;
                if (w_half_end) begin
                    w_state_nxt = IDLE;
                    w_done_p    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_d    <= 1'b0;
            r_en_dd   <= 1'b0;
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
            r_done_p  <= 1'b0;
            sen       <= 1'b0;
            sck       <= CPOL;
            sdat      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            r_en_d   <= en;
            r_en_dd  <= r_en_d;
            r_state  <= w_state_nxt;
            sen      <= w_sen_p;
            sck      <= w_sck_p;
            sdat     <= w_sdat_p;
            // done and rdata follow the FSM by one extra cycle so they line up
            // with the registered sen falling.
            r_done_p <= w_done_p;
            done     <= r_done_p;
            if (r_done_p) begin
                rdata <= r_cap;
            end
            if (r_state == IDLE) begin
                if (w_en_rise) begin
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    r_phase   <= 1'b0;
                end
            end else if (w_half_end) begin
                r_div_cnt <= '0;
                if (r_state == SHIFT) begin
                    r_phase <= ~r_phase;
                    if (r_phase && !w_last_bit) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Datapath registers: fully rewritten by every frame, so no reset needed.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && w_en_rise) begin
            r_shreg <= data;
        end
        // Sample sdi on the edge that closes the active half of each bit.
        if ((r_state == SHIFT) && r_phase && w_half_end) begin
            r_cap[w_bit_idx] <= sdi;
        end
    end

endmodule

// File: tb/tb_sif_master.sv
`timescale 1ns/1ps
module tb_sif_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  en, sdi, sck, sdat, sen, busy, done, lb, psdi;
    logic [7:0]  d0, d2, rd0, rd2;
    logic [11:0] d1, rd1;

    int errors = 0;
    int checks = 0;

    assign sdi[0] = lb[0] ? sdat[0] : psdi[0];
    assign sdi[1] = lb[1] ? sdat[1] : psdi[1];
    assign sdi[2] = lb[2] ? sdat[2] : psdi[2];

    sif_master #(.DW(8), .DIV(1), .MSB_FIRST(1'b0), .CPOL(1'b0)) u0 (
        .clk(clk), .rst(rst_n), .en(en[0]), .data(d0), .sdi(sdi[0]),
        .sck(sck[0]), .sdat(sdat[0]), .sen(sen[0]), .busy(busy[0]),
        .done(done[0]), .rdata(rd0));
    sif_master #(.DW(12), .DIV(3), .MSB_FIRST(1'b1), .CPOL(1'b1)) u1 (
        .clk(clk), .rst(rst_n), .en(en[1]), .data(d1), .sdi(sdi[1]),
        .sck(sck[1]), .sdat(sdat[1]), .sen(sen[1]), .busy(busy[1]),
        .done(done[1]), .rdata(rd1));
    sif_master #(.DW(8), .DIV(2), .MSB_FIRST(1'b1), .CPOL(1'b0)) u2 (
        .clk(clk), .rst(rst_n), .en(en[2]), .data(d2), .sdi(sdi[2]),
        .sck(sck[2]), .sdat(sdat[2]), .sen(sen[2]), .busy(busy[2]),
        .done(done[2]), .rdata(rd2));

    // Instance configuration as seen by the reference model
    function automatic int dw_of(input int k);
        return (k == 1) ? 12 : 8;
    endfunction
    function automatic int div_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction
    function automatic bit msb_of(input int k);
        return (k != 0);
    endfunction
    function automatic bit cpol_of(input int k);
        return (k == 1);
    endfunction
    function automatic logic [15:0] mask_of(input int k);
        return (16'h1 << dw_of(k)) - 16'h1;
    endfunction
    function automatic int exp_len(input int k);
        return 2 * div_of(k) * (dw_of(k) + 1);
    endfunction
    function automatic logic [15:0] rdw(input int k);
        case (k)
            0:       return {8'h00, rd0};
            1:       return {4'h0, rd1};
            default: return {8'h00, rd2};
        endcase
    endfunction
    // i-th bit on the wire for word w
    function automatic logic order_bit(input int k, input logic [15:0] w, input int i);
        return msb_of(k) ? w[dw_of(k) - 1 - i] : w[i];
    endfunction
    function automatic logic [15:0] exp_seq(input int k, input logic [15:0] w);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < dw_of(k); i++) s[i] = order_bit(k, w, i);
        return s;
    endfunction

    // Observed frame statistics and a peripheral model per instance
    int          frames[3], sen_len[3], last_len[3], edges[3], stray[3];
    int          done_cnt[3], lead[3], fall_gap[3], busy_run[3], idle_run[3];
    int          alen[3], amin[3], amax[3], pidx[3];
    logic        done_at_fall[3], sdat_after[3], p_sen[3], p_act[3], p_fell[3];
    logic [15:0] seq[3], rd_done[3], pw[3];

    function automatic void clr(input int k);
        frames[k] = 0; last_len[k] = -1; edges[k] = 0; stray[k] = 0;
        done_cnt[k] = 0; lead[k] = -1; fall_gap[k] = -1; alen[k] = 0;
        amin[k] = 1000; amax[k] = 0; seq[k] = '0; rd_done[k] = 16'hxxxx;
        done_at_fall[k] = 1'b0; sdat_after[k] = 1'b1;
    endfunction

    always @(negedge clk) begin
        logic act;
        for (int k = 0; k < 3; k++) begin
            act = sck[k] ^ cpol_of(k);
            if (p_fell[k]) sdat_after[k] = sdat[k];
            if (sen[k] && !p_sen[k]) begin
                frames[k]++; sen_len[k] = 0; edges[k] = 0; seq[k] = '0; lead[k] = busy_run[k];
            end
            if (!sen[k] && p_sen[k]) begin
                last_len[k] = sen_len[k]; fall_gap[k] = idle_run[k]; done_at_fall[k] = done[k];
            end
            if (sen[k]) sen_len[k]++;
            if (act && !p_act[k]) begin
                if (sen[k]) begin
                    if (edges[k] < 16) seq[k][edges[k]] = sdat[k];
                    edges[k]++;
                end else begin
                    stray[k]++;
                end
            end
            if (act) begin
                alen[k]++;
            end else if (p_act[k]) begin
                if (alen[k] < amin[k]) amin[k] = alen[k];
                if (alen[k] > amax[k]) amax[k] = alen[k];
                alen[k] = 0;
            end
            if (done[k]) begin done_cnt[k]++; rd_done[k] = rdw(k); end
            // Peripheral shifts its next bit out when sck returns to idle
            if (!sen[k]) begin
                pidx[k] = 0; psdi[k] = order_bit(k, pw[k], 0);
            end else if (!act && p_act[k]) begin
                pidx[k]++;
                if (pidx[k] < dw_of(k)) psdi[k] = order_bit(k, pw[k], pidx[k]);
            end
            if (busy[k]) begin busy_run[k]++; idle_run[k] = 0; end
            else begin idle_run[k]++; busy_run[k] = 0; end
            p_fell[k] = !sen[k] && p_sen[k];
            p_sen[k] = sen[k];
            p_act[k] = act;
        end
    end

    task automatic set_data(input int k, input logic [15:0] w);
        case (k)
            0:       d0 = w[7:0];
            1:       d1 = w[11:0];
            default: d2 = w[7:0];
        endcase
    endtask

    task automatic start_frame(input int k, input logic [15:0] w);
        @(negedge clk);
        set_data(k, w);
        en[k] = 1'b1;
        repeat (4) @(negedge clk);
        en[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string name);
        int n = 0;
        while (done[k] !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        checks++;
        if (done[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s: done not seen after %0d cycles, got %b want 1", name, n, done[k]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (sen[k] !== 1'b0) begin errors++; $display("FAIL rst_sen%0d: got %b want 0", k, sen[k]); end
            checks++; if (sck[k] !== cpol_of(k)) begin errors++; $display("FAIL rst_sck%0d: got %b want %b", k, sck[k], cpol_of(k)); end
            checks++; if (sdat[k] !== 1'b0) begin errors++; $display("FAIL rst_sdat%0d: got %b want 0", k, sdat[k]); end
            checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL rst_busy%0d: got %b want 0", k, busy[k]); end
            checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL rst_done%0d: got %b want 0", k, done[k]); end
            checks++; if (rdw(k) !== 16'h0) begin errors++; $display("FAIL rst_rdata%0d: got %h want 0", k, rdw(k)); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 3'b000 || sen !== 3'b000) begin errors++; $display("FAIL rst_idle: busy=%b sen=%b want 000 000", busy, sen); end
    endtask

    task automatic test_latency;
        logic [15:0] w;
        w = 16'h00A5;
        pw[0] = 16'($urandom) & mask_of(0);
        clr(0);
        @(negedge clk);
        d0 = w[7:0]; en[0] = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy[0] !== 1'b0 || sen[0] !== 1'b0) begin errors++; $display("FAIL lat_e1: busy=%b sen=%b want 0 0", busy[0], sen[0]); end
        @(posedge clk); #1;
        checks++; if (busy[0] !== 1'b1 || sen[0] !== 1'b0) begin errors++; $display("FAIL lat_e2: busy=%b sen=%b want 1 0", busy[0], sen[0]); end
        @(posedge clk); #1;
        checks++; if (sen[0] !== 1'b1) begin errors++; $display("FAIL lat_e3: sen=%b want 1", sen[0]); end
        @(negedge clk); en[0] = 1'b0;
        wait_done(0, "lat_done");
        checks++; if (last_len[0] != 18) begin errors++; $display("FAIL lat_senlen: got %0d want 18", last_len[0]); end
        checks++; if (edges[0] != 8) begin errors++; $display("FAIL lat_edges: got %0d want 8", edges[0]); end
        checks++; if (seq[0] !== exp_seq(0, w)) begin errors++; $display("FAIL lat_sdat: got %h want %h", seq[0], exp_seq(0, w)); end
        checks++; if (lead[0] != 1) begin errors++; $display("FAIL lat_busylead: got %0d want 1", lead[0]); end
        checks++; if (fall_gap[0] != 1) begin errors++; $display("FAIL lat_busyfall: got %0d want 1", fall_gap[0]); end
        checks++; if (done_at_fall[0] !== 1'b1) begin errors++; $display("FAIL lat_donealign: got %b want 1", done_at_fall[0]); end
        checks++; if (sdat_after[0] !== 1'b0) begin errors++; $display("FAIL lat_sdatidle: got %b want 0", sdat_after[0]); end
        checks++; if (rd_done[0] !== pw[0]) begin errors++; $display("FAIL lat_rdata: got %h want %h", rd_done[0], pw[0]); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt[0] != 1 || frames[0] != 1) begin errors++; $display("FAIL lat_once: done=%0d frames=%0d want 1 1", done_cnt[0], frames[0]); end
    endtask

    task automatic test_wide;
        pw[1] = 16'($urandom) & mask_of(1);
        clr(1);
        start_frame(1, 16'h0C3A);
        wait_done(1, "wide_done");
        checks++; if (last_len[1] != 78) begin errors++; $display("FAIL wide_senlen: got %0d want 78", last_len[1]); end
        checks++; if (edges[1] != 12) begin errors++; $display("FAIL wide_edges: got %0d want 12", edges[1]); end
        checks++; if (seq[1] !== exp_seq(1, 16'h0C3A)) begin errors++; $display("FAIL wide_sdat: got %h want %h", seq[1], exp_seq(1, 16'h0C3A)); end
        checks++; if (amin[1] != 3 || amax[1] != 3) begin errors++; $display("FAIL wide_phase: got %0d..%0d want 3..3", amin[1], amax[1]); end
        checks++; if (sck[1] !== 1'b1) begin errors++; $display("FAIL wide_idle: got %b want 1", sck[1]); end
        checks++; if (rd_done[1] !== pw[1]) begin errors++; $display("FAIL wide_rdata: got %h want %h", rd_done[1], pw[1]); end
        checks++; if (stray[1] != 0) begin errors++; $display("FAIL wide_stray: got %0d want 0", stray[1]); end
    endtask

    task automatic test_loopback;
        for (int k = 0; k < 3; k += 2) begin
            lb[k] = 1'b1;
            clr(k);
            start_frame(k, 16'h005C);
            wait_done(k, "lb_done");
            checks++; if (rd_done[k] !== 16'h005C) begin errors++; $display("FAIL lb_rdata%0d: got %h want 005c", k, rd_done[k]); end
            repeat (5) @(negedge clk);
            checks++; if (rdw(k) !== 16'h005C) begin errors++; $display("FAIL lb_hold%0d: got %h want 005c", k, rdw(k)); end
            lb[k] = 1'b0;
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int k;
            logic [15:0] w;
            k = int'($urandom_range(0, 2));
            w = 16'($urandom) & mask_of(k);
            pw[k] = 16'($urandom) & mask_of(k);
            clr(k);
            start_frame(k, w);
            wait_done(k, "rnd_done");
            checks++; if (last_len[k] != exp_len(k)) begin errors++; $display("FAIL rnd_senlen%0d: got %0d want %0d", k, last_len[k], exp_len(k)); end
            checks++; if (edges[k] != dw_of(k)) begin errors++; $display("FAIL rnd_edges%0d: got %0d want %0d", k, edges[k], dw_of(k)); end
            checks++; if (seq[k] !== exp_seq(k, w)) begin errors++; $display("FAIL rnd_sdat%0d: got %h want %h", k, seq[k], exp_seq(k, w)); end
            checks++; if (rd_done[k] !== pw[k]) begin errors++; $display("FAIL rnd_rdata%0d: got %h want %h", k, rd_done[k], pw[k]); end
            checks++; if (lead[k] != 1 || fall_gap[k] != 1) begin errors++; $display("FAIL rnd_busy%0d: lead=%0d fall=%0d want 1 1", k, lead[k], fall_gap[k]); end
            checks++; if (done_cnt[k] != 1 || done_at_fall[k] !== 1'b1) begin errors++; $display("FAIL rnd_pulse%0d: cnt=%0d align=%b want 1 1", k, done_cnt[k], done_at_fall[k]); end
            checks++; if (sdat_after[k] !== 1'b0 || stray[k] != 0) begin errors++; $display("FAIL rnd_idle%0d: sdat=%b stray=%0d want 0 0", k, sdat_after[k], stray[k]); end
        end
    endtask

    task automatic test_retrigger;
        logic [15:0] w;
        w = 16'($urandom_range(0, 254));
        pw[0] = 16'($urandom) & mask_of(0);
        clr(0);
        @(negedge clk);
        d0 = w[7:0]; en[0] = 1'b1;
        repeat (4) @(negedge clk);
        en[0] = 1'b0;
        repeat (3) @(negedge clk);
        en[0] = 1'b1; d0 = 8'hFF;
        wait_done(0, "retrig_done");
        repeat (40) @(negedge clk);
        checks++; if (frames[0] != 1) begin errors++; $display("FAIL retrig_frames: got %0d want 1", frames[0]); end
        checks++; if (done_cnt[0] != 1) begin errors++; $display("FAIL retrig_dones: got %0d want 1", done_cnt[0]); end
        checks++; if (seq[0] !== exp_seq(0, w)) begin errors++; $display("FAIL retrig_sdat: got %h want %h", seq[0], exp_seq(0, w)); end
        en[0] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_hold;
        logic [15:0] w1, w2;
        w1 = 16'($urandom) & mask_of(0);
        w2 = 16'($urandom) & mask_of(0);
        clr(0);
        @(negedge clk);
        d0 = w1[7:0]; en[0] = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (frames[0] != 1 || done_cnt[0] != 1) begin errors++; $display("FAIL hold_once: frames=%0d dones=%0d want 1 1", frames[0], done_cnt[0]); end
        checks++; if (seq[0] !== exp_seq(0, w1)) begin errors++; $display("FAIL hold_sdat1: got %h want %h", seq[0], exp_seq(0, w1)); end
        en[0] = 1'b0; d0 = w2[7:0];
        @(negedge clk);
        en[0] = 1'b1;
        wait_done(0, "hold_done2");
        checks++; if (frames[0] != 2 || done_cnt[0] != 2) begin errors++; $display("FAIL hold_second: frames=%0d dones=%0d want 2 2", frames[0], done_cnt[0]); end
        checks++; if (seq[0] !== exp_seq(0, w2)) begin errors++; $display("FAIL hold_sdat2: got %h want %h", seq[0], exp_seq(0, w2)); end
        en[0] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_abort;
        logic [15:0] w;
        int n = 0;
        pw[0] = 16'h003C;
        clr(0);
        start_frame(0, 16'($urandom) & mask_of(0));
        wait_done(0, "abort_pre");
        checks++; if (rdw(0) !== 16'h003C) begin errors++; $display("FAIL abort_prerd: got %h want 003c", rdw(0)); end
        clr(0);
        @(negedge clk);
        d0 = 8'($urandom); en[0] = 1'b1;
        while (edges[0] < 5 && n < 200) begin @(negedge clk); #1; n++; end
        checks++; if (edges[0] < 5 || sen[0] !== 1'b1) begin errors++; $display("FAIL abort_reach: edges=%0d sen=%b want 5 1", edges[0], sen[0]); end
        #1;
        en[0] = 1'b0; rst_n = 1'b0;
        #1;
        checks++; if (sen[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL abort_ctl: sen=%b busy=%b want 0 0", sen[0], busy[0]); end
        checks++; if (sck[0] !== 1'b0 || sdat[0] !== 1'b0) begin errors++; $display("FAIL abort_pins: sck=%b sdat=%b want 0 0", sck[0], sdat[0]); end
        checks++; if (rdw(0) !== 16'h0 || done[0] !== 1'b0) begin errors++; $display("FAIL abort_rd: rdata=%h done=%b want 0 0", rdw(0), done[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (done_cnt[0] != 0) begin errors++; $display("FAIL abort_nodone: got %0d want 0", done_cnt[0]); end
        w = 16'($urandom) & mask_of(0);
        pw[0] = 16'($urandom) & mask_of(0);
        clr(0);
        start_frame(0, w);
        wait_done(0, "abort_post");
        checks++; if (last_len[0] != 18 || edges[0] != 8) begin errors++; $display("FAIL abort_frame: len=%0d edges=%0d want 18 8", last_len[0], edges[0]); end
        checks++; if (seq[0] !== exp_seq(0, w)) begin errors++; $display("FAIL abort_sdat: got %h want %h", seq[0], exp_seq(0, w)); end
        checks++; if (rd_done[0] !== pw[0] || done_cnt[0] != 1) begin errors++; $display("FAIL abort_rdata: got %h/%0d want %h/1", rd_done[0], done_cnt[0], pw[0]); end
    endtask

    initial begin
        en = '0; lb = '0; d0 = '0; d1 = '0; d2 = '0;
        for (int k = 0; k < 3; k++) begin
            pw[k] = '0; p_sen[k] = 1'b0; p_act[k] = 1'b0; p_fell[k] = 1'b0;
            busy_run[k] = 0; idle_run[k] = 0; sen_len[k] = 0; pidx[k] = 0;
            clr(k);
        end
        test_reset();
        test_latency();
        test_wide();
        test_loopback();
        test_random();
        test_retrigger();
        test_hold();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
